// File: rtl/unified_mem_arbiter_if.sv
// Bundle for the unified memory arbiter: IF/MEM request channels, stall outputs
// and the single-ported memory port.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_F;
  logic              stall_M;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata, m_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, stall_F, stall_M,
           m_en, m_we, m_addr, m_wdata
  );

  // Pipeline/memory side.
  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata, m_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, stall_F, stall_M,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency memory port between the fetch
// (IF) and memory (MEM) stages. MEM has fixed priority; each access is held for
// MEM_LAT cycles and finishes with a one-cycle ready pulse.
// Optional one-entry fetch buffer enabled by defining MEMARB_IBUF_EN.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  unified_mem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 1: MEM owns the port, 0: IF
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              ibuf_hit;

`ifdef MEMARB_IBUF_EN
  logic              ibuf_v_q;
  logic [ADDR_W-1:0] ibuf_a_q;
  logic [DATA_W-1:0] ibuf_d_q;

  assign ibuf_hit = ibuf_v_q && (ibuf_a_q == bus.if_addr);

  // Fetch buffer: fill on unflushed IF completion, drop on a MEM write to the same word.
  always_ff @(posedge clk) begin
    if (reset) begin
      ibuf_v_q <= 1'b0;
      ibuf_a_q <= '0;
      ibuf_d_q <= '0;
    end else if (state_q == ST_DONE) begin
      if (!owner_q && !bus.if_flush) begin
        ibuf_v_q <= 1'b1;
        ibuf_a_q <= addr_q;
        ibuf_d_q <= if_rdata_q;
      end else if (owner_q && we_q && (addr_q == ibuf_a_q)) begin
        ibuf_v_q <= 1'b0;
      end
    end
  end
`else
  assign ibuf_hit = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Arbitration, latency count and read-data capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_req) begin
          owner_d = 1'b1;
          addr_d  = bus.mem_addr;
          we_d    = bus.mem_we;
          wdata_d = bus.mem_wdata;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = ST_BUSY;
        end else if (bus.if_req) begin
          owner_d = 1'b0;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          if (ibuf_hit) begin
`ifdef MEMARB_IBUF_EN
            if_rdata_d = ibuf_d_q;
`endif
            state_d = ST_DONE;
          end else begin
            cnt_d   = CNT_W'(MEM_LAT - 1);
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (!owner_q && bus.if_flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!we_q) begin
            if (owner_q) mem_rdata_d = bus.m_rdata;
            else         if_rdata_d  = bus.m_rdata;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port is driven straight from the latched access while BUSY.
  assign bus.m_en    = (state_q == ST_BUSY);
  assign bus.m_we    = (state_q == ST_BUSY) && we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;

  // Ready pulses in DONE; a flush arriving in DONE suppresses the fetch pulse.
  assign bus.if_ready  = (state_q == ST_DONE) && !owner_q && !bus.if_flush;
  assign bus.mem_ready = (state_q == ST_DONE) && owner_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  assign bus.stall_F = bus.if_req  && !bus.if_ready;
  assign bus.stall_M = bus.mem_req && !bus.mem_ready;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a timeline model.
module tb_unified_mem_arbiter;
  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: an access granted in cycle g is busy in g+1..g+LAT and done in g+LAT+1
  // (a buffer hit is done in g+1).
  int          cyc_n     = 0;
  bit          md_act    = 1'b0;
  bit          md_mem    = 1'b0;
  bit          md_we     = 1'b0;
  bit          md_hit    = 1'b0;
  int          md_start  = 0;
  logic [AW-1:0] md_addr = '0;
  logic [DW-1:0] md_wdata = '0;
  logic [DW-1:0] exp_if_rd  = '0;
  logic [DW-1:0] exp_mem_rd = '0;
  bit          bf_v      = 1'b0;
  logic [AW-1:0] bf_a    = '0;
  logic [DW-1:0] bf_d    = '0;
  bit          after_rst = 1'b1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, want %h", nm, cyc_n, got, exp);
    end
  endtask

  task automatic model_step();
    int ph;
    bit busy, done, e_ifr, e_memr;
    ph     = cyc_n - md_start;
    busy   = md_act && !md_hit && ph >= 1 && ph <= int'(LAT);
    done   = md_act && (md_hit ? (ph == 1) : (ph == int'(LAT) + 1));
    e_ifr  = done && !md_mem && !bus.if_flush;
    e_memr = done && md_mem;
    chk("if_ready",  32'(bus.if_ready),  32'(e_ifr));
    chk("mem_ready", 32'(bus.mem_ready), 32'(e_memr));
    chk("if_rdata",  bus.if_rdata,  exp_if_rd);
    chk("mem_rdata", bus.mem_rdata, exp_mem_rd);
    chk("m_en",      32'(bus.m_en),  32'(busy));
    chk("m_we",      32'(bus.m_we),  32'(busy && md_we));
    chk("stall_F",   32'(bus.stall_F), 32'(bus.if_req && !e_ifr));
    chk("stall_M",   32'(bus.stall_M), 32'(bus.mem_req && !e_memr));
    if (after_rst) begin
      chk("m_addr_rst",  32'(bus.m_addr), 32'd0);
      chk("m_wdata_rst", bus.m_wdata, 32'd0);
    end else if (busy) begin
      chk("m_addr", 32'(bus.m_addr), 32'(md_addr));
      if (md_mem) chk("m_wdata", bus.m_wdata, md_wdata);
    end
    // Advance to the next cycle.
    after_rst = 1'b0;
    if (reset) begin
      md_act = 1'b0; exp_if_rd = '0; exp_mem_rd = '0; bf_v = 1'b0; after_rst = 1'b1;
    end else if (md_act) begin
      if (busy && !md_mem && bus.if_flush) begin
        md_act = 1'b0;
      end else if (busy && ph == int'(LAT)) begin
        if (!md_we) begin
          if (md_mem) exp_mem_rd = bus.m_rdata;
          else        exp_if_rd  = bus.m_rdata;
        end
      end else if (done) begin
        if (!md_mem && !bus.if_flush) begin
          bf_v = 1'b1; bf_a = md_addr; bf_d = exp_if_rd;
        end
        if (md_mem && md_we && bf_v && bf_a == md_addr) bf_v = 1'b0;
        md_act = 1'b0;
      end
    end else if (bus.mem_req) begin
      md_act = 1'b1; md_mem = 1'b1; md_we = bus.mem_we; md_hit = 1'b0;
      md_addr = bus.mem_addr; md_wdata = bus.mem_wdata; md_start = cyc_n;
    end else if (bus.if_req) begin
      md_act = 1'b1; md_mem = 1'b0; md_we = 1'b0; md_hit = 1'b0;
      md_addr = bus.if_addr; md_start = cyc_n;
`ifdef MEMARB_IBUF_EN
      if (bf_v && bf_a == bus.if_addr) begin
        md_hit = 1'b1; exp_if_rd = bf_d;
      end
`endif
    end
    cyc_n++;
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic end_cycle();
    #1;
    model_step();
  endtask

  task automatic clear_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle(); clear_inputs(); end_cycle();
    end
  endtask

  task automatic fetch_full(input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int c = 0; c <= int'(LAT) + 1; c++) begin
      begin_cycle();
      if (c == 0) begin bus.if_req = 1'b1; bus.if_addr = a; bus.m_rdata = d; end
      end_cycle();
    end
    begin_cycle(); clear_inputs(); end_cycle();
  endtask

  initial begin
    clear_inputs();
    bus.m_rdata = '0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin begin_cycle(); end_cycle(); end
    begin_cycle(); reset = 1'b0; end_cycle();
    chk("rst_m_en", 32'(bus.m_en), 32'd0);

    // Single fetch.
    begin_cycle(); bus.if_req = 1'b1; bus.if_addr = 5; bus.m_rdata = 32'h8C010004; end_cycle();
    chk("t1_stall_c0", 32'(bus.stall_F), 32'd1);
    begin_cycle(); end_cycle();
    chk("t1_m_en_c1", 32'(bus.m_en), 32'd1);
    chk("t1_stall_c1", 32'(bus.stall_F), 32'd1);
    begin_cycle(); end_cycle();
    chk("t1_m_en_c2", 32'(bus.m_en), 32'd1);
    chk("t1_stall_c2", 32'(bus.stall_F), 32'd1);
    begin_cycle(); end_cycle();
    chk("t1_ready_c3", 32'(bus.if_ready), 32'd1);
    chk("t1_rdata_c3", bus.if_rdata, 32'h8C010004);
    begin_cycle(); clear_inputs(); end_cycle();

    // Simultaneous IF and MEM: MEM first.
    begin_cycle();
    bus.if_req = 1'b1; bus.if_addr = 12; bus.mem_req = 1'b1; bus.mem_we = 1'b0;
    bus.mem_addr = 9; bus.m_rdata = 32'h11112222;
    end_cycle();
    begin_cycle(); end_cycle();
    chk("t2_m_addr_c1", 32'(bus.m_addr), 32'd9);
    begin_cycle(); end_cycle();
    begin_cycle(); bus.mem_req = 1'b0; end_cycle();
    chk("t2_mem_ready_c3", 32'(bus.mem_ready), 32'd1);
    chk("t2_mem_rdata_c3", bus.mem_rdata, 32'h11112222);
    begin_cycle(); end_cycle();
    chk("t2_m_en_c4", 32'(bus.m_en), 32'd0);
    begin_cycle(); end_cycle();
    chk("t2_m_addr_c5", 32'(bus.m_addr), 32'd12);
    begin_cycle(); end_cycle();
    begin_cycle(); end_cycle();
    chk("t2_if_ready_c7", 32'(bus.if_ready), 32'd1);
    begin_cycle(); clear_inputs(); end_cycle();

    // MEM write; request dropped during BUSY.
    begin_cycle();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 3; bus.mem_wdata = 32'hDEADBEEF;
    end_cycle();
    for (int c = 1; c <= 2; c++) begin
      begin_cycle(); bus.mem_req = 1'b0; bus.mem_wdata = '0; end_cycle();
      chk("t3_m_we", 32'(bus.m_we), 32'd1);
      chk("t3_m_addr", 32'(bus.m_addr), 32'd3);
      chk("t3_m_wdata", bus.m_wdata, 32'hDEADBEEF);
    end
    begin_cycle(); end_cycle();
    chk("t3_mem_ready_c3", 32'(bus.mem_ready), 32'd1);
    chk("t3_mem_rdata_c3", bus.mem_rdata, 32'h11112222);
    idle(1);

    // Flush of an in-flight fetch.
    begin_cycle(); bus.if_req = 1'b1; bus.if_addr = 6; end_cycle();
    begin_cycle(); bus.if_req = 1'b0; bus.if_flush = 1'b1; end_cycle();
    chk("t4_m_en_c1", 32'(bus.m_en), 32'd1);
    begin_cycle(); bus.if_flush = 1'b0; end_cycle();
    chk("t4_m_en_c2", 32'(bus.m_en), 32'd0);
    begin_cycle(); end_cycle();
    chk("t4_if_ready_c3", 32'(bus.if_ready), 32'd0);
    idle(1);

    // Reset in the middle of a MEM read.
    begin_cycle(); bus.mem_req = 1'b1; bus.mem_addr = 7; bus.m_rdata = 32'h0BADF00D; end_cycle();
    begin_cycle(); bus.mem_req = 1'b0; end_cycle();
    begin_cycle(); reset = 1'b1; end_cycle();
    chk("t5_m_en_c2", 32'(bus.m_en), 32'd1);
    begin_cycle(); reset = 1'b0; end_cycle();
    chk("t5_m_en_c3", 32'(bus.m_en), 32'd0);
    chk("t5_mem_ready_c3", 32'(bus.mem_ready), 32'd0);
    chk("t5_mem_rdata_c3", bus.mem_rdata, 32'd0);
    chk("t5_m_addr_c3", 32'(bus.m_addr), 32'd0);
    idle(2);

`ifdef MEMARB_IBUF_EN
    // Buffered refetch, then invalidation by a write to the same word.
    fetch_full(5, 32'hA5A50005);
    begin_cycle(); bus.if_req = 1'b1; bus.if_addr = 5; bus.m_rdata = '0; end_cycle();
    begin_cycle(); end_cycle();
    chk("t6_hit_ready_c1", 32'(bus.if_ready), 32'd1);
    chk("t6_hit_m_en_c1", 32'(bus.m_en), 32'd0);
    chk("t6_hit_rdata_c1", bus.if_rdata, 32'hA5A50005);
    begin_cycle(); clear_inputs(); end_cycle();
    begin_cycle(); bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 5; bus.mem_wdata = 32'h1; end_cycle();
    begin_cycle(); bus.mem_req = 1'b0; end_cycle();
    idle(3);
    begin_cycle(); bus.if_req = 1'b1; bus.if_addr = 5; bus.m_rdata = 32'h00000001; end_cycle();
    begin_cycle(); end_cycle();
    chk("t6_miss_ready_c1", 32'(bus.if_ready), 32'd0);
    chk("t6_miss_m_en_c1", 32'(bus.m_en), 32'd1);
    begin_cycle(); end_cycle();
    begin_cycle(); end_cycle();
    chk("t6_miss_ready_c3", 32'(bus.if_ready), 32'd1);
    begin_cycle(); clear_inputs(); end_cycle();
`else
    fetch_full(5, 32'hA5A50005);
    begin_cycle(); bus.if_req = 1'b1; bus.if_addr = 5; end_cycle();
    begin_cycle(); end_cycle();
    chk("t6_nobuf_ready_c1", 32'(bus.if_ready), 32'd0);
    chk("t6_nobuf_m_en_c1", 32'(bus.m_en), 32'd1);
    begin_cycle(); end_cycle();
    begin_cycle(); end_cycle();
    chk("t6_nobuf_ready_c3", 32'(bus.if_ready), 32'd1);
    begin_cycle(); clear_inputs(); end_cycle();
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      begin_cycle();
      reset         = ($urandom_range(0, 99) == 0);
      bus.if_req    = ($urandom_range(0, 9) < 5);
      bus.if_addr   = AW'($urandom_range(0, 7));
      bus.if_flush  = ($urandom_range(0, 9) == 0);
      bus.mem_req   = ($urandom_range(0, 9) < 3);
      bus.mem_we    = $urandom_range(0, 1) == 1;
      bus.mem_addr  = AW'($urandom_range(0, 7));
      bus.mem_wdata = $urandom;
      bus.m_rdata   = $urandom;
      end_cycle();
    end
    begin_cycle(); reset = 1'b0; clear_inputs(); end_cycle();
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
